// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO consecutive DATA_WIDTH words from an FWFT FIFO
// into one RATIO*DATA_WIDTH beat. A word flagged s_last closes the beat early.
// The output beat is fully registered; s_read is the only combinational output.
module stream_upsizer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RATIO      = 4,
  parameter int unsigned CNT_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_empty_n,
  input  logic [DATA_WIDTH-1:0]         s_dout,
  input  logic                          s_last,
  output logic                          s_read,
  input  logic                          m_full_n,
  output logic                          m_write,
  output logic [RATIO*DATA_WIDTH-1:0]   m_din,
  output logic [RATIO-1:0]              m_keep,
  output logic                          m_last
);

  logic [DATA_WIDTH-1:0]       stage [RATIO-1];
  logic [CNT_WIDTH-1:0]        cnt;

  logic                        out_valid;
  logic [RATIO*DATA_WIDTH-1:0] out_data;
  logic [RATIO-1:0]            out_keep;
  logic                        out_last;

  logic                        pop;
  logic                        out_free;
  logic                        closing;
  logic [RATIO*DATA_WIDTH-1:0] beat_data;
  logic [RATIO-1:0]            beat_keep;

  assign pop      = out_valid & m_full_n;
  assign out_free = !out_valid | m_full_n;
  assign closing  = (cnt == CNT_WIDTH'(RATIO - 1)) | s_last;
  // A closing word needs room in the output register; staging words do not.
  assign s_read   = reset & s_empty_n & (!closing | out_free);

  assign m_write  = out_valid;
  assign m_din    = out_data;
  assign m_keep   = out_keep;
  assign m_last   = out_last;

  // Assemble the candidate beat: staged lanes below cnt, head word at cnt, zeros above.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int unsigned k = 0; k < RATIO - 1; k++) begin
      if (k < 32'(cnt)) beat_data[k*DATA_WIDTH +: DATA_WIDTH] = stage[k];
    end
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (k == 32'(cnt)) beat_data[k*DATA_WIDTH +: DATA_WIDTH] = s_dout;
      if (k <= 32'(cnt)) beat_keep[k] = 1'b1;
    end
  end

  // Lane counter and staging lanes: stage non-closing words, restart on close.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      for (int unsigned k = 0; k < RATIO - 1; k++) stage[k] <= '0;
    end else if (s_read) begin
      if (closing) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          if (k == 32'(cnt)) stage[k] <= s_dout;
        end
      end
    end
  end

  // Output register: load on a closing accept (even while popping), else clear on pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (s_read && closing) begin
      out_valid <= 1'b1;
      out_data  <= beat_data;
      out_keep  <= beat_keep;
      out_last  <= s_last;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_upsizer.sv
// Self-checking bench for stream_upsizer with a packet-packing scoreboard.
module tb_stream_upsizer;

  localparam int unsigned DW = 32;
  localparam int unsigned R  = 4;

  logic            clk;
  logic            reset;
  logic            s_empty_n;
  logic [DW-1:0]   s_dout;
  logic            s_last;
  logic            s_read;
  logic            m_full_n;
  logic            m_write;
  logic [R*DW-1:0] m_din;
  logic [R-1:0]    m_keep;
  logic            m_last;

  typedef struct {
    logic [R*DW-1:0] data;
    logic [R-1:0]    keep;
    logic            last;
  } beat_t;

  beat_t         expq[$];
  logic [DW-1:0] cur[$];
  int            checks = 0;
  int            errors = 0;

  stream_upsizer #(.DATA_WIDTH(DW), .RATIO(R), .CNT_WIDTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_empty_n(s_empty_n),
    .s_dout   (s_dout),
    .s_last   (s_last),
    .s_read   (s_read),
    .m_full_n (m_full_n),
    .m_write  (m_write),
    .m_din    (m_din),
    .m_keep   (m_keep),
    .m_last   (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare transferred beats against the scoreboard, then record accepted words.
  always @(negedge clk) begin
    if (reset) begin
      if (m_write && m_full_n) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got data=%h keep=%h last=%b, expected no beat", m_din, m_keep, m_last);
        end else begin
          beat_t e;
          e = expq.pop_front();
          if (m_din !== e.data || m_keep !== e.keep || m_last !== e.last) begin
            errors++;
            $display("FAIL beat: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                     m_din, m_keep, m_last, e.data, e.keep, e.last);
          end
        end
      end
      if (s_read) begin
        cur.push_back(s_dout);
        if (cur.size() == R || s_last) begin
          beat_t b;
          b.data = '0;
          for (int i = 0; i < cur.size(); i++) b.data[i*DW +: DW] = cur[i];
          b.keep = R'((1 << cur.size()) - 1);
          b.last = s_last;
          expq.push_back(b);
          cur.delete();
        end
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] d, input logic l, output int waited);
    bit got;
    got = 0;
    waited = 0;
    s_empty_n = 1'b1;
    s_dout = d;
    s_last = l;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (s_read) got = 1;
      else waited++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: word %h not accepted, expected acceptance within 200 cycles", d);
    end
    @(posedge clk);
    #1;
    s_empty_n = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && expq.size() != 0; c++) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats outstanding, expected 0", expq.size());
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_write !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle: got m_write=%b, expected 0", m_write);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    s_empty_n = 1'b1;
    s_dout = 32'hDEAD_BEEF;
    s_last = 1'b0;
    m_full_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_write !== 1'b0 || m_din !== '0 || m_keep !== '0 || m_last !== 1'b0 || s_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got write=%b din=%h keep=%h last=%b read=%b, expected all 0",
               m_write, m_din, m_keep, m_last, s_read);
    end
    s_empty_n = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_beats();
    int w;
    int total;
    total = 0;
    for (int i = 1; i <= 8; i++) begin
      push_word(DW'(i), 1'b0, w);
      total += w;
      if (i == 4 || i == 8) begin
        logic [R*DW-1:0] exp_d;
        if (i == 4) exp_d = {32'h4, 32'h3, 32'h2, 32'h1};
        else        exp_d = {32'h8, 32'h7, 32'h6, 32'h5};
        checks++;
        if (m_write !== 1'b1 || m_din !== exp_d || m_keep !== 4'hF || m_last !== 1'b0) begin
          errors++;
          $display("FAIL full_beat%0d: got write=%b din=%h keep=%h last=%b, expected 1 %h f 0",
                   i / 4, m_write, m_din, m_keep, m_last, exp_d);
        end
      end
    end
    checks++;
    if (total != 0) begin
      errors++;
      $display("FAIL full_stream: got %0d stall cycles, expected 0", total);
    end
    drain();
  endtask

  task automatic test_short_packet();
    int w;
    push_word(32'hA, 1'b0, w);
    push_word(32'hB, 1'b1, w);
    checks++;
    if (m_write !== 1'b1 || m_din !== {32'h0, 32'h0, 32'hB, 32'hA} || m_keep !== 4'h3 || m_last !== 1'b1) begin
      errors++;
      $display("FAIL short_packet: got write=%b din=%h keep=%h last=%b, expected 1 0..0b0000000a 3 1",
               m_write, m_din, m_keep, m_last);
    end
  endtask

  task automatic test_single_word();
    int w;
    push_word(32'h55, 1'b1, w);
    checks++;
    if (m_write !== 1'b1 || m_din !== (R*DW)'(32'h55) || m_keep !== 4'h1 || m_last !== 1'b1) begin
      errors++;
      $display("FAIL single_word: got write=%b din=%h keep=%h last=%b, expected 1 55 1 1",
               m_write, m_din, m_keep, m_last);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int w;
    int total;
    logic [R*DW-1:0] beat1;
    beat1 = {32'h14, 32'h13, 32'h12, 32'h11};
    m_full_n = 1'b0;
    total = 0;
    for (int i = 1; i <= 7; i++) begin
      push_word(DW'(32'h10 + i), 1'b0, w);
      total += w;
    end
    checks++;
    if (total != 0) begin
      errors++;
      $display("FAIL bp_staging: got %0d stall cycles, expected 0", total);
    end
    s_empty_n = 1'b1;
    s_dout = 32'h18;
    s_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (s_read !== 1'b0 || m_write !== 1'b1 || m_din !== beat1 || m_keep !== 4'hF) begin
        errors++;
        $display("FAIL bp_hold: got read=%b write=%b din=%h keep=%h, expected 0 1 %h f",
                 s_read, m_write, m_din, m_keep, beat1);
      end
    end
    @(posedge clk);
    #1;
    m_full_n = 1'b1;
    push_word(32'h18, 1'b0, w);
    checks++;
    if (m_write !== 1'b1 || m_din !== {32'h18, 32'h17, 32'h16, 32'h15}) begin
      errors++;
      $display("FAIL bp_beat2: got write=%b din=%h, expected 1 00000018000000170000001600000015",
               m_write, m_din);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int w;
    m_full_n = 1'b0;
    for (int i = 1; i <= 6; i++) push_word(DW'(32'h20 + i), 1'b0, w);
    reset = 1'b0;
    expq.delete();
    cur.delete();
    #1;
    checks++;
    if (m_write !== 1'b0 || m_din !== '0 || m_keep !== '0 || m_last !== 1'b0 || s_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got write=%b din=%h keep=%h last=%b read=%b, expected all 0",
               m_write, m_din, m_keep, m_last, s_read);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_full_n = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(DW'(32'hA0 + i), 1'b0, w);
    checks++;
    if (m_write !== 1'b1 || m_din !== {32'hA4, 32'hA3, 32'hA2, 32'hA1} || m_keep !== 4'hF || m_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_clean_beat: got write=%b din=%h keep=%h last=%b, expected 1 a4a3a2a1 f 0",
               m_write, m_din, m_keep, m_last);
    end
    drain();
  endtask

  task automatic test_random_bubbles();
    bit done;
    done = 0;
    fork
      begin
        int w;
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 2) == 0) begin
            int gap;
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
              @(negedge clk);
              checks++;
              if (s_read !== 1'b0) begin
                errors++;
                $display("FAIL empty_read: got s_read=%b, expected 0", s_read);
              end
              @(posedge clk);
              #1;
            end
          end
          push_word($urandom(), (i == 999) || ($urandom_range(0, 4) == 0), w);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_full_n = ($urandom_range(0, 2) != 0);
        end
      end
    join
    m_full_n = 1'b1;
    drain();
  endtask

  initial begin
    s_empty_n = 1'b0;
    s_dout = '0;
    s_last = 1'b0;
    m_full_n = 1'b1;
    test_reset();
    test_full_beats();
    test_short_packet();
    test_single_word();
    test_backpressure();
    test_reset_mid();
    test_random_bubbles();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
